// File: rtl/mips_mem_pkg.sv
// Shared definitions for the data-memory responder: FSM states, counter width, error code.
package mips_mem_pkg;

    // Responder handshake states
    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } mem_state_t;

    // Width of the latency down-counter; covers LATENCY values 1..15
    localparam int unsigned LAT_W = 4;

    // resp_err value reported for misaligned or out-of-range addresses
    localparam logic MEM_ERR_ADDR = 1'b1;

endpackage

// File: rtl/dmem_array.sv
// Word-addressed 32-bit RAM: synchronous write, registered synchronous read, no reset.
module dmem_array #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned ADDR_W      = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Write when enabled; read port always registers the addressed word
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: valid/ready request, programmable latency, one-cycle response.
module dmem_responder
    import mips_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    mem_state_t        state;
    mem_state_t        state_nx;
    logic [LAT_W-1:0]  cnt;
    logic              lat_write;
    logic [31:0]       lat_addr;
    logic [31:0]       lat_wdata;
    logic [IDX_W-1:0]  lat_idx;
    logic [IDX_W-1:0]  arr_idx;
    logic              addr_err;
    logic              accept;
    logic              access_done;
    logic              arr_we;
    logic [31:0]       arr_rdata;

    assign accept      = (state == IDLE) && req_valid;
    assign access_done = (state == ACCESS) && (cnt == '0);

    // Decode of the latched address: word index plus alignment/range check
    assign lat_idx  = lat_addr[IDX_W+1:2];
    assign addr_err = (lat_addr[1:0] != 2'b00) || (lat_addr[31:IDX_W+2] != '0);

    // In IDLE the array is pointed at the incoming address so that the registered
    // read is already valid one edge after acceptance, even when LATENCY is 1.
    assign arr_idx = (state == IDLE) ? req_addr[IDX_W+1:2] : lat_idx;
    assign arr_we  = access_done && lat_write && !addr_err;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .addr  (arr_idx),
        .wdata (lat_wdata),
        .rdata (arr_rdata)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and state-decoded handshake outputs
    always_comb begin
        state_nx   = state;
        req_ready  = 1'b0;
        busy       = 1'b1;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    state_nx = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt == '0) begin
                    state_nx = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                state_nx   = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Request latch, latency counter and registered response fields
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= '0;
            lat_write  <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            if (accept) begin
                lat_write <= req_write;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                cnt       <= LAT_W'(LATENCY - 1);
            end else if ((state == ACCESS) && (cnt != '0)) begin
                cnt <= cnt - LAT_W'(1);
            end
            if (access_done) begin
                resp_err   <= addr_err ? MEM_ERR_ADDR : 1'b0;
                resp_rdata <= (addr_err || lat_write) ? '0 : arr_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder at LATENCY 2, 1 and 15 against a word-array model.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned NDUT  = 3;
    localparam int unsigned LATS [NDUT] = '{2, 1, 15};

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid  [NDUT];
    logic        req_ready  [NDUT];
    logic        req_write  [NDUT];
    logic [31:0] req_addr   [NDUT];
    logic [31:0] req_wdata  [NDUT];
    logic        resp_valid [NDUT];
    logic [31:0] resp_rdata [NDUT];
    logic        resp_err   [NDUT];
    logic        busy       [NDUT];

    logic [31:0] mdl   [NDUT][DEPTH];
    bit          known [NDUT][DEPTH];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        dmem_responder #(
            .DEPTH_WORDS (DEPTH),
            .LATENCY     (LATS[g])
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_write  (req_write[g]),
            .req_addr   (req_addr[g]),
            .req_wdata  (req_wdata[g]),
            .resp_valid (resp_valid[g]),
            .resp_rdata (resp_rdata[g]),
            .resp_err   (resp_err[g]),
            .busy       (busy[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r < 8)       return 32'($urandom_range(0, 15)) * 4;
        else if (r == 8) return 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(1, 3));
        else             return 32'h400 + 32'($urandom_range(0, 1000)) * 4;
    endfunction

    // One complete transaction on DUT k; all expectations come from the word model.
    task automatic do_req(input int k, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wd, input string tag);
        int unsigned lat;
        bit          e;
        int unsigned idx;
        int          n;
        int          t;
        int          busy_cnt;
        int          resp_cnt;
        int          first;
        int          bad_ready;
        logic [31:0] rd;
        logic        er;
        lat = LATS[k];
        e   = (addr % 4 != 0) || (addr / 4 >= DEPTH);
        idx = e ? 0 : int'(addr / 4);
        n = 0;
        while (!req_ready[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("%s ready_wait", tag), 32'(req_ready[k]), 32'd1);
        req_valid[k] = 1'b1;
        req_write[k] = wr;
        req_addr[k]  = addr;
        req_wdata[k] = wd;
        @(negedge clk);
        // request has been accepted; disturb the inputs to show they are not used
        req_valid[k] = 1'b0;
        req_write[k] = 1'($urandom_range(0, 1));
        req_addr[k]  = $urandom;
        req_wdata[k] = $urandom;
        t = 1; busy_cnt = 0; resp_cnt = 0; first = 0; bad_ready = 0;
        rd = 'x; er = 1'bx;
        while (t <= 40) begin
            if (!busy[k]) break;
            busy_cnt++;
            if (req_ready[k]) bad_ready++;
            if (resp_valid[k]) begin
                resp_cnt++;
                if (first == 0) begin
                    first = t;
                    rd    = resp_rdata[k];
                    er    = resp_err[k];
                end
            end
            @(negedge clk);
            t++;
        end
        chk($sformatf("%s latency", tag), 32'(first), 32'(lat + 1));
        chk($sformatf("%s resp_pulses", tag), 32'(resp_cnt), 32'd1);
        chk($sformatf("%s busy_cycles", tag), 32'(busy_cnt), 32'(lat + 1));
        chk($sformatf("%s ready_while_busy", tag), 32'(bad_ready), 32'd0);
        chk($sformatf("%s ready_after", tag), 32'(req_ready[k]), 32'd1);
        chk($sformatf("%s err", tag), 32'(er), 32'(e));
        chk($sformatf("%s err_hold", tag), 32'(resp_err[k]), 32'(e));
        if (wr || e) begin
            chk($sformatf("%s rdata_zero", tag), rd, 32'd0);
            chk($sformatf("%s rdata_hold", tag), resp_rdata[k], 32'd0);
        end else if (known[k][idx]) begin
            chk($sformatf("%s rdata", tag), rd, mdl[k][idx]);
            chk($sformatf("%s rdata_hold", tag), resp_rdata[k], mdl[k][idx]);
        end
        if (wr && !e) begin
            mdl[k][idx]   = wd;
            known[k][idx] = 1'b1;
        end
    endtask

    initial begin
        int acc [$];
        int overlap;
        int n;
        logic [31:0] a;

        for (int k = 0; k < NDUT; k++) begin
            req_valid[k] = 1'b0;
            req_write[k] = 1'b0;
            req_addr[k]  = '0;
            req_wdata[k] = '0;
        end
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            chk($sformatf("reset%0d ready", k), 32'(req_ready[k]), 32'd1);
            chk($sformatf("reset%0d resp_valid", k), 32'(resp_valid[k]), 32'd0);
            chk($sformatf("reset%0d rdata", k), resp_rdata[k], 32'd0);
            chk($sformatf("reset%0d err", k), 32'(resp_err[k]), 32'd0);
            chk($sformatf("reset%0d busy", k), 32'(busy[k]), 32'd0);
        end

        // store then load at LATENCY=2
        do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, "st_10");
        do_req(0, 1'b0, 32'h10, 32'h0, "ld_10");
        chk("ld_10 deadbeef", resp_rdata[0], 32'hDEADBEEF);

        // address errors
        do_req(0, 1'b1, 32'h0, 32'h600DF00D, "st_0");
        do_req(0, 1'b0, 32'h12, 32'h0, "ld_misaligned");
        do_req(0, 1'b1, 32'h400, 32'h55, "st_out_of_range");
        chk("oor err", 32'(resp_err[0]), 32'd1);
        do_req(0, 1'b0, 32'h0, 32'h0, "ld_0_after_oor");
        chk("ld_0 intact", resp_rdata[0], 32'h600DF00D);

        // reset during ACCESS of a store discards it
        do_req(0, 1'b1, 32'h20, 32'hAAAA, "st_20_pre");
        req_valid[0] = 1'b1;
        req_write[0] = 1'b1;
        req_addr[0]  = 32'h20;
        req_wdata[0] = 32'h1234;
        @(negedge clk);
        req_valid[0] = 1'b0;
        chk("abort in_access", 32'(busy[0]), 32'd1);
        rst = 1'b0;
        #1;
        chk("abort ready", 32'(req_ready[0]), 32'd1);
        chk("abort resp_valid", 32'(resp_valid[0]), 32'd0);
        chk("abort rdata", resp_rdata[0], 32'd0);
        chk("abort err", 32'(resp_err[0]), 32'd0);
        chk("abort busy", 32'(busy[0]), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        do_req(0, 1'b0, 32'h20, 32'h0, "ld_20_after_abort");
        chk("ld_20 preserved", resp_rdata[0], 32'hAAAA);

        // LATENCY=1 back-to-back loads with req_valid held high
        do_req(1, 1'b1, 32'h8, 32'h13572468, "l1_st_8");
        req_valid[1] = 1'b1;
        req_write[1] = 1'b0;
        req_addr[1]  = 32'h8;
        overlap = 0;
        for (int i = 0; i < 14; i++) begin
            if (req_ready[1]) acc.push_back(i);
            if (busy[1] && req_ready[1]) overlap++;
            @(negedge clk);
        end
        req_valid[1] = 1'b0;
        chk("b2b accept_count", 32'(acc.size()), 32'd5);
        for (int i = 1; i < acc.size(); i++) begin
            chk($sformatf("b2b spacing%0d", i), 32'(acc[i] - acc[i-1]), 32'd3);
        end
        chk("b2b ready_while_busy", 32'(overlap), 32'd0);
        n = 0;
        while (busy[1] && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("b2b drained", 32'(busy[1]), 32'd0);
        chk("b2b last_rdata", resp_rdata[1], 32'h13572468);

        // LATENCY=15 single load
        do_req(2, 1'b1, 32'h3C, 32'hCAFE0015, "l15_st");
        do_req(2, 1'b0, 32'h3C, 32'h0, "l15_ld");

        // randomized traffic on every latency
        for (int k = 0; k < NDUT; k++) begin
            for (int i = 0; i < 20; i++) begin
                a = rand_addr();
                do_req(k, 1'($urandom_range(0, 1)), a, $urandom, $sformatf("rnd%0d_%0d", k, i));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder that serves load/store requests from the pipelined core's MEM stage over a valid/ready request channel and a one-cycle response pulse. It replaces the zero-latency data memory with a word-addressed RAM behind a programmable access latency. It also exports a `busy` flag that the hazard unit uses to freeze the pipeline while an access is outstanding.

## Interface
Parameters:
- `DEPTH_WORDS`, 256: number of 32-bit words; power of two, at least 4.
- `LATENCY`, 2: wait cycles from request acceptance to response; legal range 1..15.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `req_valid` input 1: core presents a request.
- `req_ready` output 1: responder can accept; high only in IDLE.
- `req_write` input 1: 1 means store, 0 means load.
- `req_addr` input 32: byte address.
- `req_wdata` input 32: store data.
- `resp_valid` output 1: one-cycle pulse; response fields are valid.
- `resp_rdata` output 32: load data; 0 for stores and errors.
- `resp_err` output 1: request was misaligned or out of range.
- `busy` output 1: a request is in flight (state is not IDLE).

## Operation
- FSM states:
  - IDLE: `req_ready`=1.
    - If `req_valid` is high, latch write, address, and wdata.
    - Load `cnt`=LATENCY-1 and go to ACCESS.
  - ACCESS: if `cnt`≠0, decrement `cnt`. If `cnt`=0, perform the access, register the result, and go to RESP.
  - RESP: `resp_valid`=1 for exactly this cycle, then go to IDLE.
- Address decode:
  - Word index = `req_addr[log2(DEPTH_WORDS)+1:2]`.
  - Error if `req_addr[1:0]`≠0 or any bit above the index field is nonzero.
- Errored request: no array write, `resp_err`=1, `resp_rdata`=0. It still takes the full latency.
- Store: the array is written at the ACCESS→RESP edge. `resp_rdata`=0.
- Load: `resp_rdata` is the word at the index at the ACCESS→RESP edge.
- Request inputs are ignored outside IDLE. The latched copies are used throughout, so the core may change `req_*` after acceptance.
- `resp_rdata` and `resp_err` hold their values after RESP until the next response.
- Array contents are not reset and are undefined until written.

## Timing
- Reset values: state IDLE, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `busy`=0, `cnt`=0.
- Acceptance at edge N: `resp_valid` is high in the cycle after edge N+LATENCY.
- `req_ready` returns high after edge N+LATENCY+1. Peak throughput is one request per LATENCY+2 cycles.
- `busy`, `req_ready`, and `resp_valid` are decoded from registered state, with no combinational path from inputs.
- `busy` rises in the cycle after acceptance. The core must treat the acceptance cycle itself as stalled (`req_valid && req_ready`).
- Reset asserted mid-operation: immediate return to IDLE with outputs at reset values. A store whose ACCESS→RESP edge has not occurred is discarded.
- `req_valid` may drop without acceptance only when `req_ready`=0. No request is lost in this case, because none was captured.

## Structure
- Shared package `mips_mem_pkg` holds:
  - the state enum {IDLE, ACCESS, RESP};
  - the `LATENCY` width constant (4 bits);
  - the error-code constant.
- One sub-module, `dmem_array`: DEPTH_WORDS×32, synchronous write enable, registered synchronous read, no reset.
- The FSM, latency counter, request latch, and address-check logic live in `dmem_responder`.

## Test plan
- Reset, then store 0xDEADBEEF to 0x10, then load 0x10, with LATENCY=2. Required: each `resp_valid` pulse arrives exactly 2 edges after acceptance; the load returns 0xDEADBEEF with `resp_err`=0.
- LATENCY=1, back-to-back loads with `req_valid` held high. Required: acceptances are spaced 3 cycles apart; `req_ready` is low while `busy`=1.
- Load from 0x12. Required: `resp_err`=1 and `resp_rdata`=0. Store 0x55 to 0x400 (out of range for 256 words). Required: `resp_err`=1, and a subsequent load of 0x0 is unaffected.
- After acceptance, change `req_addr`/`req_wdata`. Required: the response reflects the latched values only.
- Assert `rst` low during ACCESS of a store of 0x1234 to 0x20. Required: outputs return to reset values at once; a later load of 0x20 does not return 0x1234 (location pre-written with 0xAAAA returns 0xAAAA).
- LATENCY=15, single load. Required: `busy` is high for 16 cycles; `resp_valid` is high for exactly one cycle.
